// File: rtl/fifo_burst_ctrl_pkg.sv
// Shared definitions for the burst FIFO exerciser: default sizing and the
// controller FSM state encoding.
package fifo_burst_ctrl_pkg;

   localparam int DATA_W  = 8;
   localparam int MAX_LEN = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/fifo_burst_ctrl_if.sv
// FIFO-side bus of the burst controller; master is the controller, slave is
// the sibling FIFO instance.
interface fifo_burst_ctrl_if #(
   parameter int DATA_W = fifo_burst_ctrl_pkg::DATA_W
);

   logic              fifo_wr_en;
   logic [DATA_W-1:0] fifo_data_in;
   logic              fifo_full;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_data_out;
   logic              fifo_empty;

   modport master (
      output fifo_wr_en,
      output fifo_data_in,
      input  fifo_full,
      output fifo_rd_en,
      input  fifo_data_out,
      input  fifo_empty
   );

   modport slave (
      input  fifo_wr_en,
      input  fifo_data_in,
      output fifo_full,
      input  fifo_rd_en,
      output fifo_data_out,
      output fifo_empty
   );

endinterface

// File: rtl/fifo_burst_ctrl.sv
// Burst controller: writes an incrementing byte sequence into an external FIFO,
// reads it back, checks each byte and accumulates a checksum.
module fifo_burst_ctrl #(
   parameter int DATA_W  = fifo_burst_ctrl_pkg::DATA_W,
   parameter int MAX_LEN = fifo_burst_ctrl_pkg::MAX_LEN
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [3:0]               burst_len,
   input  logic [DATA_W-1:0]        seed,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [DATA_W-1:0]        checksum,
   output logic [3:0]               rx_count,
   fifo_burst_ctrl_if.master        fifo
);

   import fifo_burst_ctrl_pkg::*;

   state_t            state;
   logic [3:0]        len_r;
   logic [3:0]        wr_cnt;
   logic [3:0]        rd_cnt;
   logic [DATA_W-1:0] seed_r;
   logic              rd_pending;
   logic              wr_ok;
   logic              rd_ok;
   logic [DATA_W-1:0] expect_byte;

   // Strobes are combinational so a full/empty change takes effect the same cycle.
   assign wr_ok = (state == S_FILL)  && !fifo.fifo_full  && (wr_cnt < len_r);
   assign rd_ok = (state == S_DRAIN) && !fifo.fifo_empty && (rd_cnt < len_r);

   assign fifo.fifo_wr_en   = wr_ok;
   assign fifo.fifo_rd_en   = rd_ok;
   assign fifo.fifo_data_in = seed_r + DATA_W'(wr_cnt);
   assign expect_byte       = seed_r + DATA_W'(rx_count);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         len_r      <= '0;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         seed_r     <= '0;
         rd_pending <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         checksum   <= '0;
         rx_count   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  len_r      <= burst_len;
                  seed_r     <= seed;
                  wr_cnt     <= '0;
                  rd_cnt     <= '0;
                  rd_pending <= 1'b0;
                  checksum   <= '0;
                  rx_count   <= '0;
                  error      <= 1'b0;
                  if (burst_len == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else if (int'(burst_len) > MAX_LEN) begin
                     error <= 1'b1;
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_FILL;
                     busy  <= 1'b1;
                  end
               end
            end

            S_FILL: begin
               if (wr_ok) begin
                  wr_cnt <= wr_cnt + 4'd1;
                  if (wr_cnt == len_r - 4'd1)
                     state <= S_DRAIN;
               end
            end

            S_DRAIN: begin
               // Read data arrives one cycle after the accepted read, so reads
               // and captures overlap in a two-stage pipeline.
               rd_pending <= rd_ok;
               if (rd_ok)
                  rd_cnt <= rd_cnt + 4'd1;
               if (rd_pending) begin
                  checksum <= checksum + fifo.fifo_data_out;
                  rx_count <= rx_count + 4'd1;
                  if (fifo.fifo_data_out != expect_byte)
                     error <= 1'b1;
                  if (rx_count + 4'd1 == len_r) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Randomised and directed bench for fifo_burst_ctrl with a queue-style FIFO
// sibling and a sequence-level reference model.
module tb_fifo_burst_ctrl;

   localparam int DW = 8;
   localparam int ML = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    burst_len = '0;
   logic [DW-1:0] seed = '0;
   logic          busy, done, error;
   logic [DW-1:0] checksum;
   logic [3:0]    rx_count;

   int checks = 0;
   int errors = 0;

   fifo_burst_ctrl_if #(.DATA_W(DW)) bus ();

   fifo_burst_ctrl #(.DATA_W(DW), .MAX_LEN(ML)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .burst_len (burst_len),
      .seed      (seed),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .checksum  (checksum),
      .rx_count  (rx_count),
      .fifo      (bus)
   );

   always #5 clk = ~clk;

   // Sibling FIFO: registered read data, same reset, optional stall and corruption.
   logic [DW-1:0] mem [0:ML-1];
   int  wptr = 0, rptr = 0, cnt = 0, rd_seen = 0;
   int  corrupt_at = -1;
   logic stall = 1'b0;
   logic do_wr, do_rd;

   assign bus.fifo_full  = (cnt == ML) || stall;
   assign bus.fifo_empty = (cnt == 0);
   assign do_wr = bus.fifo_wr_en && !bus.fifo_full;
   assign do_rd = bus.fifo_rd_en && !bus.fifo_empty;

   always @(posedge clk) begin
      if (!rst_n) begin
         wptr <= 0; rptr <= 0; cnt <= 0; rd_seen <= 0;
         bus.fifo_data_out <= '0;
      end else begin
         if (do_wr) begin
            mem[wptr] <= bus.fifo_data_in;
            wptr <= (wptr + 1) % ML;
         end
         if (do_rd) begin
            bus.fifo_data_out <= mem[rptr] ^ ((rd_seen == corrupt_at) ? 8'h5A : 8'h00);
            rptr <= (rptr + 1) % ML;
            rd_seen <= rd_seen + 1;
         end
         cnt <= cnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
      end
   end

   // Edge counter and negedge monitor; an event seen after edge k lands on edge k+1.
   int edge_no = 0;
   always @(posedge clk) edge_no <= edge_no + 1;

   logic          mon_on = 1'b0;
   logic [DW-1:0] wr_data [$];
   int            wr_edges [$];
   int            rd_edges [$];
   int            done_edges [$];
   int            busy_cycles = 0, viol = 0;
   logic          full_seen = 1'b0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (bus.fifo_wr_en) begin
            wr_data.push_back(bus.fifo_data_in);
            wr_edges.push_back(edge_no + 1);
            if (bus.fifo_full) viol++;
         end
         if (bus.fifo_rd_en) begin
            rd_edges.push_back(edge_no + 1);
            if (bus.fifo_empty) viol++;
         end
         if (done) done_edges.push_back(edge_no);
         if (busy) busy_cycles++;
         if (done && busy) viol++;
         if (bus.fifo_full && !stall) full_seen = 1'b1;
      end
   end

   task automatic clear_mon();
      wr_data.delete(); wr_edges.delete(); rd_edges.delete(); done_edges.delete();
      busy_cycles = 0; viol = 0; full_seen = 1'b0;
   endtask

   task automatic run_burst(input int len, input logic [7:0] sd, input int corrupt_k,
                            input bit do_stall, input bit poke_busy, input bit check_timing);
      int s, d, n, waited;
      logic [7:0] b, exp_cs;
      logic exp_err;
      n       = (len >= 1 && len <= ML) ? len : 0;
      exp_err = (len > ML) || (n > 0 && corrupt_k >= 0 && corrupt_k < n);
      exp_cs  = '0;
      for (int i = 0; i < n; i++) begin
         b = sd + 8'(i);
         if (i == corrupt_k) b = b ^ 8'h5A;
         exp_cs = exp_cs + b;
      end

      @(posedge clk); #1;
      clear_mon();
      corrupt_at = (corrupt_k >= 0) ? rd_seen + corrupt_k : -1;
      mon_on = 1'b1;
      burst_len = len[3:0]; seed = sd; start = 1'b1;
      s = edge_no + 1;
      @(posedge clk); #1;
      start = 1'b0; burst_len = 4'($urandom); seed = 8'($urandom);
      waited = 0;
      while (done_edges.size() == 0 && waited < 300) begin
         if (do_stall) stall = ($urandom_range(0, 2) == 0);
         if (poke_busy && waited == 2) begin
            start = 1'b1; burst_len = 4'd9; seed = 8'hA5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         waited++;
      end
      start = 1'b0; stall = 1'b0;
      @(posedge clk); #1;
      mon_on = 1'b0;

      checks++;
      if (done_edges.size() != 1) begin
         errors++;
         $display("FAIL done_pulses len=%0d got %0d want 1", len, done_edges.size());
      end
      checks++;
      if (checksum !== exp_cs) begin
         errors++;
         $display("FAIL checksum len=%0d got %h want %h", len, checksum, exp_cs);
      end
      checks++;
      if (rx_count !== 4'(n)) begin
         errors++;
         $display("FAIL rx_count len=%0d got %0d want %0d", len, rx_count, n);
      end
      checks++;
      if (error !== exp_err) begin
         errors++;
         $display("FAIL error len=%0d got %b want %b", len, error, exp_err);
      end
      checks++;
      if (wr_data.size() != n || rd_edges.size() != n) begin
         errors++;
         $display("FAIL access_count len=%0d got wr=%0d rd=%0d want %0d",
                  len, wr_data.size(), rd_edges.size(), n);
      end
      for (int i = 0; i < n && i < wr_data.size(); i++) begin
         checks++;
         if (wr_data[i] !== sd + 8'(i)) begin
            errors++;
            $display("FAIL wr_data[%0d] got %h want %h", i, wr_data[i], sd + 8'(i));
         end
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL strobe_rules len=%0d got %0d violations want 0", len, viol);
      end
      if (done_edges.size() > 0) begin
         d = done_edges[0];
         checks++;
         if (busy_cycles != d - s) begin
            errors++;
            $display("FAIL busy_cycles len=%0d got %0d want %0d", len, busy_cycles, d - s);
         end
         if (check_timing) begin
            checks++;
            if (d != ((n == 0) ? s : s + 2 * n + 1)) begin
               errors++;
               $display("FAIL done_edge len=%0d got %0d want %0d", len, d - s,
                        (n == 0) ? 0 : 2 * n + 1);
            end
            for (int i = 0; i < n && i < wr_edges.size() && i < rd_edges.size(); i++) begin
               checks++;
               if (wr_edges[i] != s + 1 + i || rd_edges[i] != s + n + 1 + i) begin
                  errors++;
                  $display("FAIL access_edge[%0d] got wr=%0d rd=%0d want wr=%0d rd=%0d", i,
                           wr_edges[i] - s, rd_edges[i] - s, 1 + i, n + 1 + i);
               end
            end
         end
      end
      // Results must persist in IDLE.
      burst_len = 4'($urandom); seed = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (checksum !== exp_cs || rx_count !== 4'(n) || error !== exp_err || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold got cs=%h rx=%0d err=%b busy=%b want cs=%h rx=%0d err=%b busy=0",
                  checksum, rx_count, error, busy, exp_cs, n, exp_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, error, checksum, rx_count, bus.fifo_wr_en, bus.fifo_rd_en, bus.fifo_data_in} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b err=%b cs=%h rx=%0d wr=%b rd=%b din=%h want all 0",
                  busy, done, error, checksum, rx_count, bus.fifo_wr_en, bus.fifo_rd_en, bus.fifo_data_in);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_burst(4, 8'h10, -1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (checksum !== 8'h46 || rx_count !== 4'd4) begin
         errors++;
         $display("FAIL len4_seed10 got cs=%h rx=%0d want cs=46 rx=4", checksum, rx_count);
      end
      run_burst(7, 8'hFE, -1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (checksum !== 8'h07 || full_seen !== 1'b1) begin
         errors++;
         $display("FAIL len7_wrap got cs=%h full_seen=%b want cs=07 full_seen=1", checksum, full_seen);
      end
      run_burst(9, 8'h33, -1, 1'b0, 1'b0, 1'b1);
      run_burst(0, 8'h44, -1, 1'b0, 1'b0, 1'b1);
      run_burst(5, 8'h30, 2, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_abort();
      int waited;
      @(posedge clk); #1;
      clear_mon();
      corrupt_at = -1;
      mon_on = 1'b1;
      burst_len = 4'd5; seed = 8'h77; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      waited = 0;
      while (wr_data.size() < 2 && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, error, checksum, rx_count, bus.fifo_wr_en, bus.fifo_rd_en} !== '0 || waited >= 50) begin
         errors++;
         $display("FAIL abort_outputs got busy=%b done=%b err=%b cs=%h rx=%0d wr=%b rd=%b wait=%0d want all 0",
                  busy, done, error, checksum, rx_count, bus.fifo_wr_en, bus.fifo_rd_en, waited);
      end
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      mon_on = 1'b0;
      checks++;
      if (done_edges.size() != 0 || cnt != 0) begin
         errors++;
         $display("FAIL abort_no_done got done_pulses=%0d fifo_cnt=%0d want 0 0", done_edges.size(), cnt);
      end
      run_burst(3, 8'hC8, -1, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_random();
      int r, len, ck;
      bit st;
      for (int k = 0; k < 24; k++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       len = r + 1;
         else if (r == 7) len = 0;
         else             len = $urandom_range(8, 15);
         ck = -1;
         if (len >= 1 && len <= ML && $urandom_range(0, 3) == 0) ck = $urandom_range(0, len - 1);
         st = 1'($urandom_range(0, 1));
         run_burst(len, 8'($urandom), ck, st, 1'b0, !st);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_reset_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
